wave_capture: RTL and testbench



---
 rtl/wave_capture.sv | 90 +++++++++
 tb/tb_wave_capture.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// Zero-crossing triggered waveform capture into a double-buffered display RAM.
// One frame of 2^ADDR_WIDTH samples is written per trigger, then handed to the display.
module wave_capture #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_sample_ready,
  input  logic [15:0]           new_sample_in,
  input  logic                  wave_display_idle,
  output logic [ADDR_WIDTH:0]   write_address,
  output logic                  write_enable,
  output logic [7:0]            write_sample,
  output logic                  read_index
);

  typedef enum logic [1:0] {
    ARMED,
    ACTIVE,
    WAIT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_COUNT = '1;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_next;
  logic [15:0]           prev_sample;
  logic                  read_index_next;
  logic                  crossing;

  // Negative-to-non-negative transition between consecutive strobed samples.
  assign crossing = new_sample_ready & prev_sample[15] & ~new_sample_in[15];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARMED;
      count       <= '0;
      prev_sample <= '0;
      read_index  <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      read_index <= read_index_next;
      if (new_sample_ready) begin
        prev_sample <= new_sample_in;
      end
    end
  end

  // NOTE: defaults assigned first so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_next      = state;
    count_next      = count;
    read_index_next = read_index;
    case (state)
      ARMED: begin
        if (crossing) begin
          state_next = ACTIVE;
          count_next = '0;
        end
      end
      ACTIVE: begin
        if (new_sample_ready) begin
          count_next = count + 1'b1;
          if (count == LAST_COUNT) begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (wave_display_idle) begin
          read_index_next = ~read_index;
          state_next      = ARMED;
        end
      end
      default: begin
        state_next = ARMED;
      end
    endcase
  end

  // Capture always targets the half the display is not reading.
  assign write_enable  = (state == ACTIVE) & new_sample_ready;
  assign write_address = {~read_index, count};
  assign write_sample  = {~new_sample_in[15], new_sample_in[14:8]};

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture: triggering, frame fill, buffer
// hand-off, crossing boundaries, data mapping and asynchronous reset.
module tb_wave_capture;

  logic        clk;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int total = 0;
  int bad   = 0;

  wave_capture #(.ADDR_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One-cycle strobe; outputs are checked mid-cycle while the strobe is present.
  task automatic strobe(input logic [15:0] s, input logic exp_we, input logic [8:0] exp_addr,
                        input logic [7:0] exp_data, input string tag);
    @(negedge clk);
    new_sample_ready = 1'b1;
    new_sample_in    = s;
    #1;
    check({tag, " we"}, 16'(write_enable), 16'(exp_we));
    check({tag, " addr"}, 16'(write_address), 16'(exp_addr));
    if (exp_we) check({tag, " data"}, 16'(write_sample), 16'(exp_data));
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
  endtask

  // Sample i has top byte i, so its offset-binary value is i+128 modulo 256.
  task automatic run_frame(input int first, input int last, input logic half);
    for (int i = first; i <= last; i++) begin
      strobe({8'(i), 8'(i * 3)}, 1'b1, {half, 8'(i)}, 8'(i + 128), $sformatf("frame h%0d i%0d", half, i));
    end
  endtask

  task automatic hand_off(input logic exp_ri);
    @(negedge clk);
    wave_display_idle = 1'b1;
    @(posedge clk);
    #1;
    wave_display_idle = 1'b0;
    check("handoff read_index", 16'(read_index), 16'(exp_ri));
  endtask

  initial begin
    reset             = 1'b1;
    new_sample_ready  = 1'b0;
    new_sample_in     = 16'h0000;
    wave_display_idle = 1'b0;
    #1;
    check("reset we", 16'(write_enable), 16'h0);
    check("reset addr", 16'(write_address), 16'h100);
    check("reset read_index", 16'(read_index), 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Positive-to-positive never triggers.
    strobe(16'h0001, 1'b0, 9'h100, 8'h00, "arm 0001");
    strobe(16'h0002, 1'b0, 9'h100, 8'h00, "arm 0002");
    strobe(16'h0003, 1'b0, 9'h100, 8'h00, "arm 0003");

    // Frame 1: 0xF000 -> 0x0100 crossing; crossing sample itself is not stored.
    strobe(16'hF000, 1'b0, 9'h100, 8'h00, "arm F000");
    strobe(16'h0100, 1'b0, 9'h100, 8'h00, "cross 0100");
    strobe(16'h1234, 1'b1, 9'h100, 8'h92, "first 1234");
    run_frame(1, 255, 1'b1);
    strobe(16'h4000, 1'b0, 9'h100, 8'h00, "frame1 257th");

    // Display busy: no toggle and no writes while waiting.
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      new_sample_ready = (c % 5 == 0);
      new_sample_in    = 16'hFFFF;
      #1;
      check($sformatf("wait%0d we", c), 16'(write_enable), 16'h0);
      check($sformatf("wait%0d read_index", c), 16'(read_index), 16'h0);
      @(posedge clk);
      #1;
      new_sample_ready = 1'b0;
    end
    hand_off(1'b1);
    check("armed half0 addr", 16'(write_address), 16'h000);

    // 0xFFFF -> 0x8000 no trigger; 0x8000 -> 0x0000 triggers.
    strobe(16'h8000, 1'b0, 9'h000, 8'h00, "arm 8000");
    strobe(16'h0000, 1'b0, 9'h000, 8'h00, "cross 0000");
    strobe(16'h8000, 1'b1, 9'h000, 8'h00, "map 8000");
    strobe(16'h7FFF, 1'b1, 9'h001, 8'hFF, "map 7FFF");
    run_frame(2, 255, 1'b0);
    strobe(16'hFFFF, 1'b0, 9'h000, 8'h00, "frame2 257th");

    // Strobe on the hand-off edge: not written and cannot trigger.
    @(negedge clk);
    wave_display_idle = 1'b1;
    new_sample_ready  = 1'b1;
    new_sample_in     = 16'h0500;
    #1;
    check("handoff strobe we", 16'(write_enable), 16'h0);
    @(posedge clk);
    #1;
    new_sample_ready  = 1'b0;
    wave_display_idle = 1'b0;
    check("handoff2 read_index", 16'(read_index), 16'h0);
    strobe(16'hFFFF, 1'b0, 9'h100, 8'h00, "after 0500");
    strobe(16'h0001, 1'b0, 9'h100, 8'h00, "cross 0001");
    strobe(16'h0200, 1'b1, 9'h100, 8'h82, "first 0200");
    run_frame(1, 255, 1'b1);
    strobe(16'h0300, 1'b0, 9'h100, 8'h00, "frame3 257th");
    hand_off(1'b1);

    // Partial frame abandoned by a mid-cycle asynchronous reset at count=100.
    strobe(16'hFFFF, 1'b0, 9'h000, 8'h00, "arm FFFF");
    strobe(16'h0001, 1'b0, 9'h000, 8'h00, "cross 0001 b");
    run_frame(0, 99, 1'b0);
    @(negedge clk);
    new_sample_ready = 1'b1;
    new_sample_in    = 16'h1000;
    #1;
    check("pre-reset we", 16'(write_enable), 16'h1);
    check("pre-reset addr", 16'(write_address), 16'h064);
    #1;
    reset = 1'b1;
    #1;
    check("async reset we", 16'(write_enable), 16'h0);
    check("async reset addr", 16'(write_address), 16'h100);
    check("async reset read_index", 16'(read_index), 16'h0);
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    strobe(16'h1000, 1'b0, 9'h100, 8'h00, "post-reset 1000");
    strobe(16'h2000, 1'b0, 9'h100, 8'h00, "post-reset 2000");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
